// File: rtl/bitblade_column_pipe_if.sv
// Handshake bundle between the input/weight buffers, the column and the output buffer.
// Carries the beat (x/y slices, sign modes, shift codes, group length, flush) and the result.
// Optional BITBLADE_ACC_SAT_EN adds the out_sat result flag.
interface bitblade_column_pipe_if #(
  parameter int N_PE    = 16,
  parameter int LANES   = 16,
  parameter int SHIFT_W = 3,
  parameter int CNT_W   = 8,
  parameter int ACC_W   = 32
);
  logic                      in_valid;
  logic                      in_ready;
  logic [N_PE*2*LANES-1:0]   x_data;
  logic [N_PE*2*LANES-1:0]   y_data;
  logic [N_PE-1:0]           sign_x;
  logic [N_PE-1:0]           sign_y;
  logic [N_PE*SHIFT_W-1:0]   shift_code;
  logic [CNT_W-1:0]          acc_len;
  logic                      flush;
  logic                      out_valid;
  logic                      out_ready;
  logic [ACC_W-1:0]          out_data;
`ifdef BITBLADE_ACC_SAT_EN
  logic                      out_sat;

  modport master (
    output in_valid, x_data, y_data, sign_x, sign_y, shift_code, acc_len, flush, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );
  modport slave (
    input  in_valid, x_data, y_data, sign_x, sign_y, shift_code, acc_len, flush, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
`else
  modport master (
    output in_valid, x_data, y_data, sign_x, sign_y, shift_code, acc_len, flush, out_ready,
    input  in_ready, out_valid, out_data
  );
  modport slave (
    input  in_valid, x_data, y_data, sign_x, sign_y, shift_code, acc_len, flush, out_ready,
    output in_ready, out_valid, out_data
  );
`endif
endinterface

// File: rtl/bitblade_column_pipe.sv
// Purpose: N_PE bit-serial PEs form signed 2-bit slice dot products, shift them per PE,
//   sum them in a registered two-level adder tree and accumulate runtime-length groups.
// Latency: beat accepted at edge t -> group result (single-beat group) out_valid after edge t+3.
// Backpressure: a stalled result (out_valid && !out_ready) freezes every stage; in_ready follows.
// Ports: clk, reset (sync, active-high), bus (slave modport of bitblade_column_pipe_if).
// Macro BITBLADE_ACC_SAT_EN: saturating accumulator plus sticky out_sat flag; undefined = wrap.
module bitblade_column_pipe #(
  parameter int N_PE    = 16,
  parameter int LANES   = 16,
  parameter int SHIFT_W = 3,
  parameter int CNT_W   = 8,
  parameter int ACC_W   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  bitblade_column_pipe_if.slave bus
);
  localparam int PS_W = 5 + $clog2(LANES);  // per-PE sum width
  localparam int LW   = 2 * LANES;          // bits per PE on x/y
  localparam int HALF = N_PE / 2;

  // ---------------------------------------------------------------- control
  logic en;
  logic accept;
  logic out_valid_q;

  assign en           = !(out_valid_q && !bus.out_ready);
  assign accept       = bus.in_valid && en;
  assign bus.in_ready = en;

  // ---------------------------------------------------------------- PE math
  // A 2-bit slice is -2..1 when signed, 0..3 when unsigned; widen first so the
  // product and the lane sum can never overflow the per-PE register.
  function automatic logic signed [PS_W-1:0] slice_prod(
    input logic [1:0] x, input logic [1:0] y, input logic sx, input logic sy);
    logic signed [PS_W-1:0] xw;
    logic signed [PS_W-1:0] yw;
    xw = {{(PS_W-2){sx & x[1]}}, x};
    yw = {{(PS_W-2){sy & y[1]}}, y};
    return xw * yw;
  endfunction

  function automatic logic [ACC_W-1:0] shift_term(
    input logic signed [PS_W-1:0] s, input logic [SHIFT_W-1:0] c);
    logic [ACC_W-1:0] ext;
    ext = ACC_W'(s);
    return ext << {c, 1'b0};
  endfunction

  logic signed [PS_W-1:0] pe_sum [N_PE];

  always_comb begin
    for (int p = 0; p < N_PE; p++) begin
      pe_sum[p] = '0;
      for (int l = 0; l < LANES; l++) begin
        pe_sum[p] = pe_sum[p] + slice_prod(bus.x_data[p*LW + 2*l +: 2],
                                           bus.y_data[p*LW + 2*l +: 2],
                                           bus.sign_x[p], bus.sign_y[p]);
      end
    end
  end

  // ---------------------------------------------------------------- beat counter
  // The group length is latched on the first beat so acc_len may change mid-group.
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] cur_len;
  logic             beat_last;

  assign cur_len   = (cnt_q == '0) ? bus.acc_len : len_q;
  assign beat_last = (cnt_q == cur_len);

  // ---------------------------------------------------------------- stage registers
  logic                   s1_vld, s1_last;
  logic signed [PS_W-1:0] s1_sum  [N_PE];
  logic [SHIFT_W-1:0]     s1_code [N_PE];

  logic                   s2a_vld, s2a_last;
  logic [ACC_W-1:0]       s2a_lo, s2a_hi;

  logic                   s2_vld, s2_last;
  logic [ACC_W-1:0]       s2_term;

  logic [ACC_W-1:0]       acc_q;
  logic [ACC_W-1:0]       out_data_q;

  // First adder-tree level: two half-column partial sums.
  logic [ACC_W-1:0] lo_sum, hi_sum;

  always_comb begin
    lo_sum = '0;
    hi_sum = '0;
    for (int p = 0; p < HALF; p++)
      lo_sum = lo_sum + shift_term(s1_sum[p], s1_code[p]);
    for (int p = HALF; p < N_PE; p++)
      hi_sum = hi_sum + shift_term(s1_sum[p], s1_code[p]);
  end

  // ---------------------------------------------------------------- accumulator add
  logic [ACC_W-1:0] acc_next;
`ifdef BITBLADE_ACC_SAT_EN
  logic [ACC_W:0] acc_wide;
  logic           acc_ovf;
  logic           sat_q;
  logic           out_sat_q;

  always_comb begin
    acc_wide = {acc_q[ACC_W-1], acc_q} + {s2_term[ACC_W-1], s2_term};
    acc_ovf  = acc_wide[ACC_W] ^ acc_wide[ACC_W-1];
    acc_next = acc_wide[ACC_W-1:0];
    if (acc_ovf)
      acc_next = acc_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  end

  assign bus.out_sat = out_sat_q;
`else
  assign acc_next = acc_q + s2_term;
`endif

  // ---------------------------------------------------------------- sequential
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      len_q       <= '0;
      s1_vld      <= 1'b0;
      s1_last     <= 1'b0;
      for (int p = 0; p < N_PE; p++) begin
        s1_sum[p]  <= '0;
        s1_code[p] <= '0;
      end
      s2a_vld     <= 1'b0;
      s2a_last    <= 1'b0;
      s2a_lo      <= '0;
      s2a_hi      <= '0;
      s2_vld      <= 1'b0;
      s2_last     <= 1'b0;
      s2_term     <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
`ifdef BITBLADE_ACC_SAT_EN
      sat_q       <= 1'b0;
      out_sat_q   <= 1'b0;
`endif
    end else if (bus.flush) begin
      // Drop everything in flight, but let a pending result finish its handshake.
      cnt_q   <= '0;
      s1_vld  <= 1'b0;
      s2a_vld <= 1'b0;
      s2_vld  <= 1'b0;
      acc_q   <= '0;
`ifdef BITBLADE_ACC_SAT_EN
      sat_q   <= 1'b0;
`endif
      if (out_valid_q && bus.out_ready)
        out_valid_q <= 1'b0;
    end else if (en) begin
      // S1
      s1_vld <= accept;
      if (accept) begin
        s1_last <= beat_last;
        for (int p = 0; p < N_PE; p++) begin
          s1_sum[p]  <= pe_sum[p];
          s1_code[p] <= bus.shift_code[p*SHIFT_W +: SHIFT_W];
        end
        if (cnt_q == '0)
          len_q <= bus.acc_len;
        cnt_q <= beat_last ? '0 : cnt_q + 1'b1;
      end

      // S2a / S2
      s2a_vld  <= s1_vld;
      s2a_last <= s1_last;
      s2a_lo   <= lo_sum;
      s2a_hi   <= hi_sum;

      s2_vld   <= s2a_vld;
      s2_last  <= s2a_last;
      s2_term  <= s2a_lo + s2a_hi;

      // S3: en=1 here means any held result is firing (or there is none),
      // so out_valid drops unless a new group completes this same cycle.
      if (s2_vld && s2_last) begin
        out_data_q  <= acc_next;
        out_valid_q <= 1'b1;
        acc_q       <= '0;
`ifdef BITBLADE_ACC_SAT_EN
        out_sat_q   <= sat_q | acc_ovf;
        sat_q       <= 1'b0;
`endif
      end else begin
        out_valid_q <= 1'b0;
        if (s2_vld) begin
          acc_q <= acc_next;
`ifdef BITBLADE_ACC_SAT_EN
          sat_q <= sat_q | acc_ovf;
`endif
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
endmodule

// File: doc/bitblade_column_pipe.md
Name: bitblade_column_pipe

Overview:
- Parametrised, pipelined successor to the fixed 16-PE BitBlade column.
- N_PE bit-serial PEs each form a signed dot product of LANES pairs of 2-bit slices.
- Each PE sum is shifted by its own runtime shift code; the shifted sums go through a registered adder tree and into a group accumulator.
- Sits between the input/weight buffers and the output buffer. Adds valid/ready flow control, a runtime group length and flush, none of which the fixed column has.

Parameters:
- N_PE, 16, number of PEs in the column (power of 2, 2..64)
- LANES, 16, 2-bit slice pairs per PE per beat (x and y buses are 2*LANES bits per PE)
- SHIFT_W, 3, shift-code width per PE; shift applied = 2*code bits
- CNT_W, 8, width of the group-length field
- ACC_W, 32, accumulator/output width (signed)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- x_data  in  N_PE*2*LANES  packed activation slices; PE p uses bits [p*2*LANES +: 2*LANES]; lane l uses bits [2l+1:2l]
- y_data  in  N_PE*2*LANES  packed weight slices, same layout
- sign_x  in  N_PE  1 = PE p treats its x slices as 2-bit two's complement (-2..1), else unsigned (0..3)
- sign_y  in  N_PE  same for y
- shift_code  in  N_PE*SHIFT_W  per-PE shift code, sampled with the beat
- acc_len  in  CNT_W  group length minus 1; sampled on the first beat of each group
- flush  in  1  drops the partial group and all in-flight beats
- out_valid  out  1  group result valid
- out_ready  in  1  downstream accepts the result
- out_data  out  ACC_W  signed group sum

Behaviour:
- Interface: one clock domain (clk); reset is synchronous and active-high.
- Reset: out_valid=0, out_data=0, in_ready=1, all stage valids=0, beat counter=0, accumulator=0.
- Global advance: en = !(out_valid && !out_ready). in_ready = en. When en=0, every pipeline register holds its value.
- Stage S1, at the edge after a beat is accepted:
  - Per-PE sum = sum over lanes of x_l*y_l, using signed or unsigned slice interpretation as set by sign_x/sign_y.
  - Per-PE sum width is sign-extended to 5+clog2(LANES) bits. The register also holds the shift code and a last tag.
- Beat counter in the input stage:
  - At cnt=0, a beat latches len=acc_len.
  - A beat is tagged last when cnt==len. The counter then returns to 0; otherwise it increments.
  - acc_len=0 makes every beat its own group.
- Stage S2: each PE sum is shifted left by 2*code and sign-extended to ACC_W. The N_PE terms are summed and registered together with valid and last.
- Stage S3, the accumulator, when S2 is valid and en=1:
  - Not last: acc <= acc + term.
  - Last: out_data <= acc + term, out_valid <= 1, acc <= 0.
- Latency: a single-beat group is accepted at edge t and has out_valid=1 after edge t+3.
- Output handshake:
  - out_valid stays high with out_data stable until out_valid && out_ready.
  - If a new result completes in the same cycle that the old one fires, out_data reloads and out_valid stays 1.
  - Otherwise out_valid falls on the fire.
- Bubbles (in_valid=0) propagate as invalid stages and do not change acc or the counter.
- Arithmetic: sums wrap modulo 2^ACC_W (two's complement), unless the optional feature below is enabled.
- Flush, synchronous, has priority over the data path but below reset:
  - Clears S1/S2 valids, acc and the counter.
  - A pending out_valid result is kept and still completes its handshake.
  - A beat presented in the flush cycle is discarded.
- Changing acc_len mid-group has no effect until the next group starts.

Optional Feature:
- Macro: BITBLADE_ACC_SAT_EN.
- Defined: the S3 add saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. A sticky internal flag ORs into bit 0 of a 1-bit extra output, out_sat, which is valid with out_data and cleared when a group starts.
- Undefined: wrap-around arithmetic and no out_sat port.

Test Plan:
- Defaults, all PEs unsigned, every slice x=3, y=3, codes 0, acc_len=0 -> out_data=16*16*9=2304, out_valid 3 cycles after acceptance.
- PE0 only nonzero, signed x=-2 (2'b10), unsigned y=3 on all lanes, code 2 -> one PE sum = -96, shifted by 4 -> out_data=-1536.
- acc_len=3, four beats each giving term 5, with a 1-cycle bubble between beats 2 and 3 -> exactly one result of 20; no output after beat 2.
- Backpressure: out_ready=0 while a result is pending -> in_ready=0, out_data stable over 10 cycles. out_ready=1 -> the next queued result appears on the following cycle with no beat lost or duplicated.
- Flush asserted after 2 of 4 beats, then a full 4-beat group of term 1 -> result 4 (flushed beats excluded). Reset mid-group -> all outputs return to reset values on the next edge.
- With BITBLADE_ACC_SAT_EN, ACC_W=16, terms of 20000 twice -> out_data=32767 and out_sat=1. Without the macro -> out_data=-25536.
